// File: rtl/mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
// MDU_MADD_EN enables MADD/MADDU as multi-cycle accumulate starts.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8,
    MDU_MADD  = 4'd9,
    MDU_MADDU = 4'd10
  } mdu_op_e;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  function automatic logic is_mdu_start(input logic [3:0] op);
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: is_mdu_start = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU:                    is_mdu_start = 1'b1;
`endif
      default:                                is_mdu_start = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mdu_timer.sv
// Loadable down-counter; busy while nonzero, done during the last busy cycle.
module mdu_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         busy,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign busy = (cnt != '0);
  assign done = (cnt == W'(1));

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit owning HI/LO; result is computed at start
// and committed when the latency timer expires. MDU_MADD_EN adds MADD/MADDU.
module e_mdu import mdu_pkg::*; #(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_MDU_valid,
  input  logic [3:0]  E_MDUop,
  input  logic [31:0] E_RD1,
  input  logic [31:0] E_RD2,
  output logic        E_MDU_busy,
  output logic        E_MDU_stall,
  output logic [31:0] E_MDU_out
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [31:0] hi, lo, stg_hi, stg_lo;
  logic        stg_wr;
  logic        busy, done, start, is_div, idle_op;
  logic [31:0] a, b;
  logic [63:0] prod_s, prod_u;
  logic [31:0] mag_a, mag_b, den_s, den_u, sq, sr, uq, ur;
  logic [31:0] res_hi, res_lo;
  logic        res_wr;

  assign a       = E_RD1;
  assign b       = E_RD2;
  assign start   = E_MDU_valid & is_mdu_start(E_MDUop) & ~busy;
  assign is_div  = (E_MDUop == MDU_DIV) | (E_MDUop == MDU_DIVU);
  assign idle_op = E_MDU_valid & ~busy;

  mdu_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (start),
    .load_val (is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES)),
    .busy     (busy),
    .done     (done)
  );

  // Signed divide runs on magnitudes so that MIN_INT / -1 wraps cleanly.
  always_comb begin
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'b0, a} * {32'b0, b};
    mag_a  = a[31] ? -a : a;
    mag_b  = b[31] ? -b : b;
    den_s  = (mag_b == '0) ? 32'd1 : mag_b;
    den_u  = (b == '0) ? 32'd1 : b;
    sq     = mag_a / den_s;
    sr     = mag_a % den_s;
    uq     = a / den_u;
    ur     = a % den_u;
  end

  always_comb begin
    res_wr = 1'b1;
    res_hi = '0;
    res_lo = '0;
    case (E_MDUop)
      MDU_MULT:  {res_hi, res_lo} = prod_s;
      MDU_MULTU: {res_hi, res_lo} = prod_u;
      MDU_DIV: begin
        res_wr = (b != '0);
        res_lo = (a[31] ^ b[31]) ? -sq : sq;
        res_hi = a[31] ? -sr : sr;
      end
      MDU_DIVU: begin
        res_wr = (b != '0);
        res_lo = uq;
        res_hi = ur;
      end
`ifdef MDU_MADD_EN
      MDU_MADD:  {res_hi, res_lo} = {hi, lo} + prod_s;
      MDU_MADDU: {res_hi, res_lo} = {hi, lo} + prod_u;
`endif
      default:   res_wr = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi     <= '0;
      lo     <= '0;
      stg_hi <= '0;
      stg_lo <= '0;
      stg_wr <= 1'b0;
    end else begin
      if (start) begin
        stg_hi <= res_hi;
        stg_lo <= res_lo;
        stg_wr <= res_wr;
      end
      // A divide-by-zero still runs the full latency but never commits.
      if (done && stg_wr) begin
        hi <= stg_hi;
        lo <= stg_lo;
      end
      if (idle_op && E_MDUop == MDU_MTHI) hi <= a;
      if (idle_op && E_MDUop == MDU_MTLO) lo <= a;
    end
  end

  assign E_MDU_busy  = busy;
  assign E_MDU_stall = start | busy;
  assign E_MDU_out   = (E_MDU_valid && E_MDUop == MDU_MFHI) ? hi :
                       (E_MDU_valid && E_MDUop == MDU_MFLO) ? lo : 32'd0;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed table, corner sequences, random ops vs model.
module tb_e_mdu;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        E_MDU_valid = 1'b0;
  logic [3:0]  E_MDUop = 4'd0;
  logic [31:0] E_RD1 = '0, E_RD2 = '0;
  logic        E_MDU_busy, E_MDU_stall;
  logic [31:0] E_MDU_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .E_MDU_valid(E_MDU_valid), .E_MDUop(E_MDUop),
    .E_RD1(E_RD1), .E_RD2(E_RD2), .E_MDU_busy(E_MDU_busy),
    .E_MDU_stall(E_MDU_stall), .E_MDU_out(E_MDU_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int lat(input logic [3:0] op);
    case (op)
      MDU_MULT, MDU_MULTU: lat = MC;
      MDU_DIV, MDU_DIVU:   lat = DC;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU: lat = MC;
`endif
      default:             lat = 0;
    endcase
  endfunction

  // Architectural effect computed with 64-bit integer arithmetic.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = $signed(a); sb = $signed(b); ua = a; ub = b;
    case (op)
      MDU_MULT:  begin p = sa * sb; {m_hi, m_lo} = p; end
      MDU_MULTU: begin p = ua * ub; {m_hi, m_lo} = p; end
      MDU_DIV:   if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      MDU_DIVU:  if (b != 0) begin p = ua / ub; m_lo = p[31:0]; p = ua % ub; m_hi = p[31:0]; end
      MDU_MTHI:  m_hi = a;
      MDU_MTLO:  m_lo = a;
`ifdef MDU_MADD_EN
      MDU_MADD:  begin p = {m_hi, m_lo}; p = p + sa * sb; {m_hi, m_lo} = p; end
      MDU_MADDU: begin p = {m_hi, m_lo}; p = p + ua * ub; {m_hi, m_lo} = p; end
`endif
      default: ;
    endcase
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
    E_MDU_valid = 1'b1; E_MDUop = MDU_MFHI; #1;
    check({tag, "_hi"}, E_MDU_out, eh);
    E_MDUop = MDU_MFLO; #1;
    check({tag, "_lo"}, E_MDU_out, el);
    E_MDU_valid = 1'b0; E_MDUop = MDU_NONE; #1;
  endtask

  // Issue one op in an idle cycle and measure its busy window; ends at a negedge.
  task automatic exec(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    @(negedge clk);
    E_MDU_valid = 1'b1; E_MDUop = op; E_RD1 = a; E_RD2 = b; #1;
    check({tag, "_stall"}, {31'b0, E_MDU_stall}, (lat(op) != 0) ? 32'd1 : 32'd0);
    model(op, a, b);
    @(negedge clk);
    E_MDU_valid = 1'b0; E_MDUop = MDU_NONE;
    n = 0;
    while (E_MDU_busy && n < 60) begin n++; @(negedge clk); end
    check({tag, "_busy_cycles"}, n, lat(op));
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, eh, el;
  } vec_t;

  vec_t vt[9];

  initial begin
    vt[0] = '{MDU_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
    vt[1] = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[2] = '{MDU_DIVU,  32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[3] = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vt[4] = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vt[5] = '{MDU_MTHI,  32'h12345678, 32'd0,        32'h12345678, 32'h00000001};
    vt[6] = '{MDU_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E};
    vt[7] = '{MDU_NONE,  32'hDEADBEEF, 32'd5,        32'h00000002, 32'h0000000E};
    vt[8] = '{MDU_MTLO,  32'hCAFEF00D, 32'd0,        32'h00000002, 32'hCAFEF00D};

    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, E_MDU_busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_stall", {31'b0, E_MDU_stall}, 32'd0);
    check("rst_out_idle", E_MDU_out, 32'd0);
    read_hilo("rst", 32'd0, 32'd0);

    for (int i = 0; i < 9; i++) begin
      exec($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b);
      read_hilo($sformatf("vec%0d", i), vt[i].eh, vt[i].el);
    end

    // Ops arriving while busy (MTLO, MULTU, and a DIVU in the last busy cycle) are dropped.
    begin
      int n;
      @(negedge clk);
      E_MDU_valid = 1'b1; E_MDUop = MDU_MULT; E_RD1 = 32'd5; E_RD2 = 32'd7;
      n = 0;
      for (int c = 1; c <= 7; c++) begin
        @(negedge clk);
        E_MDU_valid = 1'b0; E_MDUop = MDU_NONE;
        if (c == 1) begin E_MDU_valid = 1'b1; E_MDUop = MDU_MTLO;  E_RD1 = 32'h0000DEAD; end
        if (c == 3) begin E_MDU_valid = 1'b1; E_MDUop = MDU_MULTU; E_RD1 = '1; E_RD2 = '1; end
        if (c == 5) begin E_MDU_valid = 1'b1; E_MDUop = MDU_DIVU;  E_RD1 = 32'd100; E_RD2 = 32'd7; end
        #1;
        if (c == 3) check("busy_stall", {31'b0, E_MDU_stall}, 32'd1);
        if (E_MDU_busy) n++;
      end
      check("guard_busy_cycles", n, MC);
      E_MDU_valid = 1'b0; E_MDUop = MDU_NONE;
      m_hi = 32'd0; m_lo = 32'd35;
      read_hilo("guard", 32'd0, 32'd35);
    end

    // Reset at S+4 of a divide aborts it; nothing commits afterwards.
    exec("pre_rst_mthi", MDU_MTHI, 32'h55555555, 32'd0);
    @(negedge clk);
    E_MDU_valid = 1'b1; E_MDUop = MDU_DIV; E_RD1 = 32'hFFFFFFF9; E_RD2 = 32'd2;
    @(negedge clk);
    E_MDU_valid = 1'b0; E_MDUop = MDU_NONE;
    repeat (3) @(negedge clk);
    check("pre_abort_busy", {31'b0, E_MDU_busy}, 32'd1);
    reset = 1'b1; #1;
    check("abort_busy", {31'b0, E_MDU_busy}, 32'd0);
    read_hilo("abort", 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (15) @(negedge clk);
    check("abort_busy_late", {31'b0, E_MDU_busy}, 32'd0);
    read_hilo("abort_late", 32'd0, 32'd0);

    // Accumulate: HI:LO = 0:FFFFFFFF plus 1*1.
    exec("madd_mthi", MDU_MTHI, 32'd0, 32'd0);
    exec("madd_mtlo", MDU_MTLO, 32'hFFFFFFFF, 32'd0);
    exec("maddu", MDU_MADDU, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    read_hilo("maddu", 32'd1, 32'd0);
`else
    read_hilo("maddu", 32'd0, 32'hFFFFFFFF);
`endif

    for (int i = 0; i < 60; i++) begin
      logic [3:0] op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 10));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 20);
        2: b = -$urandom_range(1, 20);
        default: b = $urandom;
      endcase
      exec($sformatf("rnd%0d", i), op, a, b);
      read_hilo($sformatf("rnd%0d", i), m_hi, m_lo);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit. It sits beside the ALU and consumes the operands, MDU opcode and valid bit latched by the D/E pipeline register. It owns the architectural HI/LO registers and models multi-cycle latency with a busy counter. It exports a stall request that the hazard unit ORs into its D-stage stall condition, plus the HI/LO read value for MFHI/MFLO forwarding into E_M_REG.

## Interface
- MULT_CYCLES, 5: busy cycles for MULT/MULTU (and MADD/MADDU); must be ≥1.
- DIV_CYCLES, 10: busy cycles for DIV/DIVU; must be ≥1.
- clk  input  1  pipeline clock.
- reset  input  1  asynchronous, active-high; one clock domain (clk), reset polarity and synchronicity fixed.
- E_MDU_valid  input  1  E-stage holds a real instruction (0 for bubbles).
- E_MDUop  input  4  operation code from mdu_pkg.
- E_RD1  input  32  forwarded rs value.
- E_RD2  input  32  forwarded rt value.
- E_MDU_busy  output  1  multi-cycle operation in flight.
- E_MDU_stall  output  1  combinational start OR busy; hazard unit stalls any D-stage MDU instruction while high.
- E_MDU_out  output  32  HI for MFHI, LO for MFLO, else 0 (combinational from current HI/LO).

## Operation
- An op is accepted only when E_MDU_valid=1.
- start = E_MDU_valid & op∈{MULT,MULTU,DIV,DIVU[,MADD,MADDU]} & !E_MDU_busy.
- On start, the operands are latched and the result is computed into staging regs. The counter is loaded with MULT_CYCLES or DIV_CYCLES.
- States: IDLE (cnt=0) and BUSY (cnt>0). Each cycle in BUSY decrements cnt. On the edge where cnt goes 1→0, HI/LO are loaded from staging and the unit returns to IDLE.
- MULT: {HI,LO} = signed 64-bit product. MULTU: unsigned product.
- DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned division.
- Divide by zero: timing is unchanged (still DIV_CYCLES busy), but HI/LO are left unmodified.
- MTHI/MTLO (rs=E_RD1) write at the next edge when not busy.
- MFHI/MFLO return the committed HI/LO.
- Ops presented while busy are ignored: no start, no write. The hazard unit guarantees this never occurs in legal flow; the bench checks the guard anyway.
- NONE and invalid codes have no effect; E_MDU_out=0.

## Timing
- Reset values: HI=0, LO=0, cnt=0, E_MDU_busy=0. E_MDU_stall=0 and E_MDU_out=0 while inputs are idle.
- Let cycle S be the start cycle.
  - E_MDU_stall=1 in S (combinational).
  - E_MDU_busy=1 in cycles S+1..S+N, where N = MULT_CYCLES or DIV_CYCLES.
  - HI/LO take new values at the edge ending S+N.
  - MFHI in cycle S+N+1 sees the result.
- Back-to-back: a new start is legal in cycle S+N+1. In S+N the unit is still busy and refuses.
- MTHI in cycle S, when start is not possible (same op slot), cannot coexist because only one op is present per cycle.
- Reset asserted mid-operation immediately clears cnt, busy and staging, and sets HI/LO to 0. The aborted result is never committed.

## Configuration
- MDU_MADD_EN defined: MADD/MADDU are decoded as multi-cycle starts. {HI,LO} = {HI,LO} + product, with the product signed or unsigned respectively and modulo 2^64. The accumulate base is HI/LO as sampled at start.
- MDU_MADD_EN undefined: MADD/MADDU codes are treated as NONE (no start, no write).

## Structure
- mdu_pkg holds:
  - The 4-bit op encodings: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8, MADD=9, MADDU=10.
  - The default cycle constants.
  - An is_mdu_start helper.
- One sub-module, mdu_timer: loadable down-counter with a done-pulse output, reused for both latencies.
- Arithmetic stays in e_mdu.

## Test plan
- Reset mid-DIV (reset at cycle S+4) → HI=LO=0, busy=0 next cycle, no later commit.
- MULT 0xFFFFFFFE × 3 → busy for exactly 5 cycles. HI=0xFFFFFFFF, LO=0xFFFFFFFA. MFLO at S+6 returns 0xFFFFFFFA.
- DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 busy cycles. DIVU 7/0 → HI/LO unchanged, busy still 10 cycles.
- MTHI 0x12345678 then MFHI next cycle → E_MDU_out=0x12345678. MTLO while busy → LO unchanged.
- MULTU issued at S+3 of a running MULT → ignored, and the first result commits unaltered.
- MDU_MADD_EN: HI:LO=0:0xFFFFFFFF, then MADDU 1×1 → HI=1, LO=0. Without the macro, the same code leaves HI/LO unchanged and busy=0.
